// File: rtl/adc_capture_trigger.sv
// adc_capture_trigger
//
// Generates a clk/2 sample clock for a 14-bit pipelined ADC, captures every
// sample into a circular buffer, freezes a snapshot around a trigger event
// (immediate or rising level crossing) with PRE samples of history, then
// streams the snapshot out over a valid/ready interface.
//
// Ports:
//   clk        in   system clock; every register lives in this domain
//   reset      in   asynchronous, active-high reset
//   adc_clk    out  ADC sample clock (clk/2, registered)
//   adc_data   in   ADC parallel output, offset-binary
//   adc_otr    in   ADC out-of-range flag
//   start      in   single-cycle arm request (honoured only when idle)
//   trig_mode  in   0 = immediate, 1 = rising level crossing
//   trig_level in   unsigned trigger threshold
//   busy       out  high whenever a capture or readout is in progress
//   done       out  one-cycle pulse when the post-trigger capture completes
//   ovr        out  sticky out-of-range flag for the current capture
//   rd_data    out  readout sample
//   rd_valid   out  readout word valid
//   rd_ready   in   downstream accepts the word
//   rd_last    out  marks the final readout word
module adc_capture_trigger #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int PRE    = 256
) (
  input  logic              clk,
  input  logic              reset,
  output logic              adc_clk,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_otr,
  input  logic              start,
  input  logic              trig_mode,
  input  logic [DATA_W-1:0] trig_level,
  output logic              busy,
  output logic              done,
  output logic              ovr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_READ
  } state_t;

  localparam logic [ADDR_W-1:0] PRE_A   = ADDR_W'(PRE);
  localparam logic [ADDR_W-1:0] PRE_M1  = ADDR_W'(PRE - 1);
  localparam logic [ADDR_W-1:0] POST_M1 = ADDR_W'(DEPTH - PRE - 1);
  localparam logic [ADDR_W:0]   RD_ALL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   RD_LAST = (ADDR_W+1)'(DEPTH - 1);

  // Sample front end
  logic              adc_clk_q, adc_clk_d;
  logic [DATA_W-1:0] s_cur_q, s_cur_d;
  logic [DATA_W-1:0] s_prev_q, s_prev_d;
  logic              otr_q, otr_d;
  logic              samp_vld_q, samp_vld_d;

  // Capture control
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              ovr_q, ovr_d;
  logic              done_q, done_d;
  logic              we;
  logic              trig_hit;

  // Readout pipeline: RAM read stage feeding an output register
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;
  logic              out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [ADDR_W-1:0] rd_addr;
  logic              issue;
  logic              move;
  logic              xfer;
  logic              last_xfer;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rdata;

  // The strobe is the cycle with adc_clk high; the sample is latched on the
  // edge where adc_clk falls and is processed in the following cycle.
  always_comb begin
    adc_clk_d  = ~adc_clk_q;
    s_cur_d    = s_cur_q;
    s_prev_d   = s_prev_q;
    otr_d      = otr_q;
    samp_vld_d = adc_clk_q;
    if (adc_clk_q) begin
      s_cur_d  = adc_data;
      s_prev_d = s_cur_q;
      otr_d    = adc_otr;
    end
  end

  // Capture FSM: next state, write pointer, counters and flags
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    trig_addr_d = trig_addr_q;
    ovr_d       = ovr_q;
    done_d      = 1'b0;
    we          = 1'b0;

    trig_hit = trig_mode ? ((s_prev_q < trig_level) && (s_cur_q >= trig_level))
                         : 1'b1;

    if (samp_vld_q && (state_q == S_PREFILL || state_q == S_ARMED ||
                       state_q == S_POST)) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (otr_q) ovr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PREFILL;
          ovr_d    = 1'b0;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      S_PREFILL: begin
        if (samp_vld_q) begin
          if (cnt_q == PRE_M1) begin
            state_d = S_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_ARMED: begin
        if (samp_vld_q && trig_hit) begin
          trig_addr_d = wr_ptr_q;
          // The trigger sample itself is post sample number one.
          if (POST_M1 == '0) begin
            done_d  = 1'b1;
            state_d = S_READ;
          end else begin
            state_d = S_POST;
            cnt_d   = ADDR_W'(1);
          end
        end
      end
      S_POST: begin
        if (samp_vld_q) begin
          if (cnt_q == POST_M1) begin
            done_d  = 1'b1;
            state_d = S_READ;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      S_READ: begin
        if (last_xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Readout: a read is issued only when the RAM stage will be free next
  // cycle, so the RAM output acts as a one-word buffer behind the output
  // register and a full-rate stream survives backpressure without loss.
  always_comb begin
    xfer      = out_vld_q && rd_ready;
    move      = ram_vld_q && (!out_vld_q || rd_ready);
    issue     = (state_q == S_READ) && (rd_cnt_q != RD_ALL) &&
                (!ram_vld_q || move);
    rd_addr   = trig_addr_q - PRE_A + rd_cnt_q[ADDR_W-1:0];
    last_xfer = xfer && out_last_q;

    rd_cnt_d = rd_cnt_q;
    if (state_q != S_READ) rd_cnt_d = '0;
    else if (issue)        rd_cnt_d = rd_cnt_q + (ADDR_W+1)'(1);

    ram_vld_d  = issue || (ram_vld_q && !move);
    ram_last_d = issue ? (rd_cnt_q == RD_LAST) : ram_last_q;

    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    if (move) begin
      out_vld_d  = 1'b1;
      out_data_d = ram_rdata;
      out_last_d = ram_last_q;
    end else if (xfer) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adc_clk_q   <= 1'b0;
      s_cur_q     <= '0;
      s_prev_q    <= '0;
      otr_q       <= 1'b0;
      samp_vld_q  <= 1'b0;
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      trig_addr_q <= '0;
      ovr_q       <= 1'b0;
      done_q      <= 1'b0;
      rd_cnt_q    <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      adc_clk_q   <= adc_clk_d;
      s_cur_q     <= s_cur_d;
      s_prev_q    <= s_prev_d;
      otr_q       <= otr_d;
      samp_vld_q  <= samp_vld_d;
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      trig_addr_q <= trig_addr_d;
      ovr_q       <= ovr_d;
      done_q      <= done_d;
      rd_cnt_q    <= rd_cnt_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Sample buffer: no reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (we)    mem[wr_ptr_q] <= s_cur_q;
    if (issue) ram_rdata     <= mem[rd_addr];
  end

  assign adc_clk  = adc_clk_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign ovr      = ovr_q;
  assign rd_data  = out_data_q;
  assign rd_valid = out_vld_q;
  assign rd_last  = out_last_q;

endmodule

// File: tb/tb_adc_capture_trigger.sv
// tb_adc_capture_trigger
//
// Directed bench for adc_capture_trigger. A ramp source advances by one after
// every sample strobe; expected readout words follow from the ramp value at
// the trigger and the pre-trigger depth.
module tb_adc_capture_trigger;

  localparam int DATA_W = 14;
  localparam int DEPTH  = 1024;

  logic              clk = 1'b0;
  logic              reset;
  logic              adc_clk;
  logic [DATA_W-1:0] adc_data;
  logic              adc_otr;
  logic              start;
  logic              trig_mode;
  logic [DATA_W-1:0] trig_level;
  logic              busy;
  logic              done;
  logic              ovr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  int checks     = 0;
  int errors     = 0;
  int ramp       = 0;
  int done_count = 0;
  logic otr_arm  = 1'b0;

  adc_capture_trigger dut (
    .clk       (clk),
    .reset     (reset),
    .adc_clk   (adc_clk),
    .adc_data  (adc_data),
    .adc_otr   (adc_otr),
    .start     (start),
    .trig_mode (trig_mode),
    .trig_level(trig_level),
    .busy      (busy),
    .done      (done),
    .ovr       (ovr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last)
  );

  always #4 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; after a strobe edge (adc_clk now low) advance the ramp and
  // apply any pending one-strobe overrange pulse.
  task automatic tick();
    @(posedge clk);
    #1;
    if (adc_clk == 1'b0) begin
      ramp++;
      adc_data = DATA_W'(ramp);
      adc_otr  = otr_arm;
      otr_arm  = 1'b0;
    end
    if (done) done_count++;
  endtask

  // Arm a capture with the ramp restarting at 0 on the first prefill sample.
  task automatic applyStimulus(input logic mode, input logic [DATA_W-1:0] level);
    trig_mode  = mode;
    trig_level = level;
    ramp       = 0;
    adc_data   = '0;
    done_count = 0;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic waitRamp(input int value);
    int n = 0;
    while (ramp < value && n < 10000) begin
      tick();
      n++;
    end
    checkOutput("ramp_reached", 32'(ramp >= value), 1);
  endtask

  task automatic waitDone();
    int n = 0;
    while (!done && n < 8000) begin
      tick();
      n++;
    end
    checkOutput("done_seen", done, 1);
  endtask

  task automatic readWords(input int first, input int duty, input bit check_rate);
    int k = 0;
    int budget = 0;
    int t = 0;
    int t_first = 0;
    int t_last = 0;
    bit stalled = 1'b0;
    logic [DATA_W-1:0] held_d = '0;
    logic held_l = 1'b0;
    while (k < DEPTH && budget < 20000) begin
      rd_ready = ($urandom_range(0, 99) < duty);
      if (stalled) begin
        checkOutput("stall_valid", rd_valid, 1);
        checkOutput("stall_data", rd_data, held_d);
        checkOutput("stall_last", rd_last, held_l);
      end
      stalled = 1'b0;
      if (rd_valid && rd_ready) begin
        checkOutput("word_data", rd_data, 32'(first + k));
        checkOutput("word_last", rd_last, 32'(k == DEPTH - 1));
        if (k == 0) t_first = t;
        if (k == DEPTH - 1) t_last = t;
        k++;
      end else if (rd_valid) begin
        stalled = 1'b1;
        held_d  = rd_data;
        held_l  = rd_last;
      end
      tick();
      t++;
      budget++;
    end
    rd_ready = 1'b0;
    checkOutput("read_count", k, DEPTH);
    checkOutput("valid_after_last", rd_valid, 0);
    if (check_rate) checkOutput("read_rate", t_last - t_first, DEPTH - 1);
  endtask

  initial begin
    reset      = 1'b1;
    adc_data   = '0;
    adc_otr    = 1'b0;
    start      = 1'b0;
    trig_mode  = 1'b0;
    trig_level = '0;
    rd_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_adc_clk", adc_clk, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_ovr", ovr, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_rd_last", rd_last, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    tick();
    checkOutput("adc_clk_1", adc_clk, 1);
    tick();
    checkOutput("adc_clk_2", adc_clk, 0);
    tick();
    checkOutput("adc_clk_3", adc_clk, 1);

    $display("[TB] level trigger on ramp, overrange pulse, start while armed");
    applyStimulus(1'b1, 14'd1000);
    checkOutput("start_busy", busy, 1);
    waitRamp(10);
    otr_arm = 1'b1;
    waitRamp(20);
    checkOutput("ovr_prefill", ovr, 1);
    waitRamp(500);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("armed_start_busy", busy, 1);
    waitDone();
    checkOutput("done_busy", busy, 1);
    tick();
    checkOutput("done_pulse_low", done, 0);
    checkOutput("ovr_read", ovr, 1);
    readWords(744, 100, 1'b1);
    checkOutput("idle_busy", busy, 0);
    checkOutput("ovr_idle", ovr, 1);
    checkOutput("done_count", done_count, 1);

    $display("[TB] immediate trigger with backpressure");
    applyStimulus(1'b0, 14'd0);
    checkOutput("ovr_cleared", ovr, 0);
    waitDone();
    readWords(0, 30, 1'b0);
    checkOutput("imm_busy", busy, 0);
    checkOutput("imm_ovr", ovr, 0);
    checkOutput("imm_done_count", done_count, 1);

    $display("[TB] reset during post-trigger capture");
    applyStimulus(1'b0, 14'd0);
    waitRamp(600);
    checkOutput("post_busy", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_valid", rd_valid, 0);
    checkOutput("mid_rst_adc_clk", adc_clk, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 14'd1000);
    waitDone();
    readWords(744, 100, 1'b1);
    checkOutput("fresh_ovr", ovr, 0);
    checkOutput("fresh_done_count", done_count, 1);

    $display("[TB] level trigger at zero never fires");
    applyStimulus(1'b1, 14'd0);
    repeat (3000) tick();
    checkOutput("zero_level_busy", busy, 1);
    checkOutput("zero_level_done", done_count, 0);
    checkOutput("zero_level_valid", rd_valid, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
